id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register and operand-select stage directly upstream of the execute ALU.
- Captures decoded instructions from ID and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts one bubble per hazard.
- Presents registered ALUSignal, ALUinA and ALUinB to the ALU, plus control and payload for the later stages.

Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register index width
- ALU_SEL_W, 5, ALU operation select width
- PERF_CNT_W, 32, width of the bubble counter (optional feature only)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID presents an instruction
- id_ready  out  1  stage accepts the ID instruction this cycle
- id_pc  in  XLEN  instruction PC
- id_rs1_addr, id_rs2_addr  in  REG_ADDR_W  source register indices
- id_rs1_en, id_rs2_en  in  1  instruction reads rs1 / rs2
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_use_imm  in  1  ALUinB takes the immediate instead of rs2
- id_alu_sel  in  ALU_SEL_W  ALU operation code, passed through unchanged
- id_rd_addr  in  REG_ADDR_W  destination register
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- flush  in  1  kill the ID and EX instructions (branch redirect)
- ex_ready  in  1  execute stage accepts the current EX instruction
- mem_rd_addr  in  REG_ADDR_W  destination register of the EX/MEM instruction
- mem_reg_write  in  1  EX/MEM instruction writes a register
- mem_result  in  XLEN  EX/MEM result
- wb_rd_addr  in  REG_ADDR_W  destination register of the MEM/WB instruction
- wb_reg_write  in  1  MEM/WB instruction writes a register
- wb_result  in  XLEN  MEM/WB result
- ex_valid  out  1  EX register holds a live instruction
- ALUSignal  out  ALU_SEL_W  registered ALU operation
- ALUinA  out  XLEN  registered operand A
- ALUinB  out  XLEN  registered operand B
- ex_store_data  out  XLEN  forwarded rs2 value for stores
- ex_pc  out  XLEN  registered PC
- ex_rd_addr  out  REG_ADDR_W  registered destination register
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control bits

Behaviour:
- Reset: all outputs registered.
  - rst=1 at a clk edge clears every output register to 0, including ex_valid; ALUSignal resets to 0 (ADD).
  - id_ready is 1 in the first cycle after reset release if flush=0 and ex_valid=0.
- Forwarding is applied per source, combinationally on the ID inputs, before capture. Priority order:
  1. mem_reg_write & mem_rd_addr!=0 & mem_rd_addr==rsX -> mem_result
  2. else wb_reg_write & wb_rd_addr!=0 & wb_rd_addr==rsX -> wb_result
  3. else id_rsX_data
- Operand selection:
  - x0 is never forwarded.
  - ALUinA = fwd_rs1.
  - ALUinB = id_use_imm ? id_imm : fwd_rs2.
  - ex_store_data = fwd_rs2.
- hazard = id_valid & ex_valid & ex_mem_read & ex_rd_addr!=0 & ((id_rs1_en & id_rs1_addr==ex_rd_addr) | (id_rs2_en & id_rs2_addr==ex_rd_addr)).
- adv = ex_ready | ~ex_valid.
- id_ready = flush | (adv & ~hazard).
- Register update per clk edge, in priority order:
  1. rst: reset all output registers.
  2. flush: ex_valid<=0, ex_reg_write<=0, ex_mem_read<=0, ex_mem_write<=0. The ID instruction is consumed and discarded.
  3. ~adv: hold every register. ex_ready=0 freezes the whole back end, so held operands are not re-forwarded.
  4. hazard or ~id_valid: bubble. ex_valid<=0 and all control bits <=0; data registers are don't-care.
  5. otherwise: capture all payload, ex_valid<=1.
- Latency: one cycle from an ID handshake (id_valid & id_ready) to ex_valid.
- A load-use hazard costs exactly one bubble. On the following cycle the load has moved to EX/MEM and its value arrives through mem_result.

Optional Feature:
- Macro: ID_EX_PERF_EN
- Defined:
  - Adds output port bubble_count, PERF_CNT_W bits.
  - Increments by 1 on every edge where a hazard bubble is inserted (adv & ~flush & hazard).
  - Wraps at 2^PERF_CNT_W to 0.
  - Cleared by rst; not cleared by flush.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with id_valid=1 -> ex_valid=0, ALUinA=0, ALUinB=0, ALUSignal=0 throughout; after release, id_ready=1.
- Immediate capture: rs1=x2, rs1_data=0x5, imm=0xFFFFFFFC, use_imm=1, alu_sel=0 -> next cycle ex_valid=1, ALUinA=0x5, ALUinB=0xFFFFFFFC, ALUSignal=0.
- Forward priority (rs1=x3, rf data 0x1):
  - mem rd=3 result 0xAAAA, wb rd=3 result 0xBBBB -> ALUinA=0xAAAA.
  - Same with mem_reg_write=0 -> ALUinA=0xBBBB.
  - rs1=x0 with mem/wb rd=0 -> ALUinA=0x0.
- Load-use: EX holds lw x5; ID presents add x6,x5,x1 -> id_ready=0 for 1 cycle, ex_valid=0 next cycle. Then add is captured with ALUinA=mem_result=0x1234, and bubble_count=1 if ID_EX_PERF_EN.
- Backpressure and flush:
  - ex_ready=0 for 3 cycles with ex_valid=1 -> all outputs stable, id_ready=0.
  - flush=1 in cycle 2 -> id_ready=1 and ex_valid=0 after that edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB forwarding and single-bubble load-use stall.
// Optional bubble counter output enabled by defining ID_EX_PERF_EN.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_SEL_W  = 5
`ifdef ID_EX_PERF_EN
    ,parameter int PERF_CNT_W = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_en,
    input  logic                  id_rs2_en,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic                  id_use_imm,
    input  logic [ALU_SEL_W-1:0]  id_alu_sel,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  flush,
    input  logic                  ex_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic                  mem_reg_write,
    input  logic [XLEN-1:0]       mem_result,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic                  wb_reg_write,
    input  logic [XLEN-1:0]       wb_result,
    output logic                  ex_valid,
    output logic [ALU_SEL_W-1:0]  ALUSignal,
    output logic [XLEN-1:0]       ALUinA,
    output logic [XLEN-1:0]       ALUinB,
    output logic [XLEN-1:0]       ex_store_data,
    output logic [XLEN-1:0]       ex_pc,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write
`ifdef ID_EX_PERF_EN
    ,output logic [PERF_CNT_W-1:0] bubble_count
`endif
);

    logic                  r_ex_valid;
    logic [ALU_SEL_W-1:0]  r_alu_sel;
    logic [XLEN-1:0]       r_alu_a;
    logic [XLEN-1:0]       r_alu_b;
    logic [XLEN-1:0]       r_store_data;
    logic [XLEN-1:0]       r_pc;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic                  r_reg_write;
    logic                  r_mem_read;
    logic                  r_mem_write;

    logic [XLEN-1:0]       w_fwd_rs1;
    logic [XLEN-1:0]       w_fwd_rs2;
    logic                  w_hazard;
    logic                  w_adv;

    // The rd!=0 terms keep x0 from ever being forwarded.
    always_comb begin
        w_fwd_rs1 = id_rs1_data;
        if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == id_rs1_addr))
            w_fwd_rs1 = mem_result;
        else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == id_rs1_addr))
            w_fwd_rs1 = wb_result;
    end

    always_comb begin
        w_fwd_rs2 = id_rs2_data;
        if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == id_rs2_addr))
            w_fwd_rs2 = mem_result;
        else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == id_rs2_addr))
            w_fwd_rs2 = wb_result;
    end

    assign w_hazard = id_valid && r_ex_valid && r_mem_read && (r_rd_addr != '0) &&
                      ((id_rs1_en && (id_rs1_addr == r_rd_addr)) ||
                       (id_rs2_en && (id_rs2_addr == r_rd_addr)));
    assign w_adv    = ex_ready || !r_ex_valid;
    assign id_ready = flush || (w_adv && !w_hazard);

    // Bubbles leave the data registers untouched; only valid and control are cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid   <= 1'b0;
            r_alu_sel    <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_store_data <= '0;
            r_pc         <= '0;
            r_rd_addr    <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else if (flush) begin
            r_ex_valid   <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else if (w_adv) begin
            if (w_hazard || !id_valid) begin
                r_ex_valid   <= 1'b0;
                r_reg_write  <= 1'b0;
                r_mem_read   <= 1'b0;
                r_mem_write  <= 1'b0;
            end else begin
                r_ex_valid   <= 1'b1;
                r_alu_sel    <= id_alu_sel;
                r_alu_a      <= w_fwd_rs1;
                r_alu_b      <= id_use_imm ? id_imm : w_fwd_rs2;
                r_store_data <= w_fwd_rs2;
                r_pc         <= id_pc;
                r_rd_addr    <= id_rd_addr;
                r_reg_write  <= id_reg_write;
                r_mem_read   <= id_mem_read;
                r_mem_write  <= id_mem_write;
            end
        end
    end

`ifdef ID_EX_PERF_EN
    logic [PERF_CNT_W-1:0] r_bubble_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_bubble_count <= '0;
        else if (w_adv && !flush && w_hazard)
            r_bubble_count <= r_bubble_count + PERF_CNT_W'(1);
    end

    assign bubble_count = r_bubble_count;
`endif

    assign ex_valid      = r_ex_valid;
    assign ALUSignal     = r_alu_sel;
    assign ALUinA        = r_alu_a;
    assign ALUinB        = r_alu_b;
    assign ex_store_data = r_store_data;
    assign ex_pc         = r_pc;
    assign ex_rd_addr    = r_rd_addr;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; checks bubble_count when ID_EX_PERF_EN is defined.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_rs1_en;
    logic        id_rs2_en;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic        id_use_imm;
    logic [4:0]  id_alu_sel;
    logic [4:0]  id_rd_addr;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        flush;
    logic        ex_ready;
    logic [4:0]  mem_rd_addr;
    logic        mem_reg_write;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd_addr;
    logic        wb_reg_write;
    logic [31:0] wb_result;
    logic        ex_valid;
    logic [4:0]  ALUSignal;
    logic [31:0] ALUinA;
    logic [31:0] ALUinB;
    logic [31:0] ex_store_data;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_sel(id_alu_sel),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .ex_ready(ex_ready),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .ex_valid(ex_valid), .ALUSignal(ALUSignal), .ALUinA(ALUinA), .ALUinB(ALUinB),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
`ifdef ID_EX_PERF_EN
        ,.bubble_count(bubble_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b1; id_pc = 32'h40;
        id_rs1_addr = 5'd2; id_rs2_addr = 5'd0; id_rs1_en = 1'b1; id_rs2_en = 1'b0;
        id_rs1_data = 32'h77; id_rs2_data = 32'h0; id_imm = 32'h9; id_use_imm = 1'b1;
        id_alu_sel = 5'd4; id_rd_addr = 5'd1; id_reg_write = 1'b1;
        id_mem_read = 1'b0; id_mem_write = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        mem_rd_addr = 5'd0; mem_reg_write = 1'b0; mem_result = 32'h0;
        wb_rd_addr = 5'd0; wb_reg_write = 1'b0; wb_result = 32'h0;

        // reset held for two edges with a valid instruction offered
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_ex_valid", 32'(ex_valid), 32'h0);
            chk("rst_alu_a", ALUinA, 32'h0);
            chk("rst_alu_b", ALUinB, 32'h0);
            chk("rst_alu_sel", 32'(ALUSignal), 32'h0);
        end
        rst = 1'b0; id_valid = 1'b0;
        #1 chk("rst_id_ready", 32'(id_ready), 32'h1);

        // immediate capture
        id_valid = 1'b1; id_pc = 32'h100; id_rs1_addr = 5'd2; id_rs1_data = 32'h5;
        id_imm = 32'hFFFF_FFFC; id_use_imm = 1'b1; id_alu_sel = 5'd0; id_rd_addr = 5'd7;
        tick();
        chk("imm_ex_valid", 32'(ex_valid), 32'h1);
        chk("imm_alu_a", ALUinA, 32'h5);
        chk("imm_alu_b", ALUinB, 32'hFFFF_FFFC);
        chk("imm_alu_sel", 32'(ALUSignal), 32'h0);
        chk("imm_rd", 32'(ex_rd_addr), 32'h7);
        chk("imm_pc", ex_pc, 32'h100);

        // forwarding priority on rs1
        id_rs1_addr = 5'd3; id_rs1_data = 32'h1; id_use_imm = 1'b0; id_alu_sel = 5'd3;
        id_rs2_addr = 5'd4; id_rs2_en = 1'b1; id_rs2_data = 32'h22;
        mem_reg_write = 1'b1; mem_rd_addr = 5'd3; mem_result = 32'hAAAA;
        wb_reg_write = 1'b1; wb_rd_addr = 5'd3; wb_result = 32'hBBBB;
        tick();
        chk("fwd_mem_a", ALUinA, 32'hAAAA);
        chk("fwd_mem_b", ALUinB, 32'h22);
        chk("fwd_alu_sel", 32'(ALUSignal), 32'h3);
        mem_reg_write = 1'b0;
        tick();
        chk("fwd_wb_a", ALUinA, 32'hBBBB);
        id_rs1_addr = 5'd0; id_rs1_data = 32'h0; mem_reg_write = 1'b1;
        mem_rd_addr = 5'd0; wb_rd_addr = 5'd0;
        tick();
        chk("fwd_x0_a", ALUinA, 32'h0);
        // rs2 forwarded from MEM/WB feeds both operand B and store data
        mem_reg_write = 1'b0; wb_rd_addr = 5'd9; wb_result = 32'hCC; id_rs2_addr = 5'd9;
        tick();
        chk("fwd_wb_b", ALUinB, 32'hCC);
        chk("fwd_wb_store", ex_store_data, 32'hCC);
        wb_reg_write = 1'b0;

        // load-use: lw x5 then add x6,x5,x1
        id_rs1_addr = 5'd1; id_rs1_data = 32'h100; id_imm = 32'h8; id_use_imm = 1'b1;
        id_rd_addr = 5'd5; id_mem_read = 1'b1; id_alu_sel = 5'd0;
        tick();
        chk("lw_mem_read", 32'(ex_mem_read), 32'h1);
        chk("lw_alu_b", ALUinB, 32'h8);
        id_rs1_addr = 5'd5; id_rs1_data = 32'hDEAD; id_rs2_addr = 5'd1; id_rs2_data = 32'h10;
        id_use_imm = 1'b0; id_rd_addr = 5'd6; id_mem_read = 1'b0;
        #1 chk("lu_id_ready", 32'(id_ready), 32'h0);
        tick();
        chk("lu_bubble_valid", 32'(ex_valid), 32'h0);
        chk("lu_bubble_regw", 32'(ex_reg_write), 32'h0);
        chk("lu_ready_after", 32'(id_ready), 32'h1);
        mem_reg_write = 1'b1; mem_rd_addr = 5'd5; mem_result = 32'h1234;
        tick();
        chk("lu_add_valid", 32'(ex_valid), 32'h1);
        chk("lu_add_a", ALUinA, 32'h1234);
        chk("lu_add_b", ALUinB, 32'h10);
        chk("lu_add_rd", 32'(ex_rd_addr), 32'h6);
`ifdef ID_EX_PERF_EN
        chk("lu_bubble_count", bubble_count, 32'h1);
`endif

        // backpressure: held operands must not pick up new forwarding data
        mem_result = 32'h5555; ex_ready = 1'b0;
        mem_reg_write = 1'b0;
        id_rs1_addr = 5'd2; id_rs1_data = 32'h99; id_rs2_addr = 5'd3; id_rs2_data = 32'h1;
        id_rd_addr = 5'd8;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_id_ready", 32'(id_ready), 32'h0);
            if (i == 0) mem_reg_write = 1'b1;
            tick();
            chk("bp_valid", 32'(ex_valid), 32'h1);
            chk("bp_alu_a", ALUinA, 32'h1234);
            chk("bp_rd", 32'(ex_rd_addr), 32'h6);
        end
        mem_reg_write = 1'b0;

        // flush while stalled
        flush = 1'b1;
        #1 chk("fl_id_ready", 32'(id_ready), 32'h1);
        tick();
        chk("fl_valid", 32'(ex_valid), 32'h0);
        chk("fl_regw", 32'(ex_reg_write), 32'h0);
        flush = 1'b0; ex_ready = 1'b1;
        #1 chk("fl_ready_after", 32'(id_ready), 32'h1);
        tick();
        chk("post_valid", 32'(ex_valid), 32'h1);
        chk("post_alu_a", ALUinA, 32'h99);
        chk("post_rd", 32'(ex_rd_addr), 32'h8);
        id_valid = 1'b0;
        tick();
        chk("idle_valid", 32'(ex_valid), 32'h0);
`ifdef ID_EX_PERF_EN
        chk("count_kept", bubble_count, 32'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
